// File: rtl/instr_feeder_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | instr_feeder_if : DIN/Run/Done handshake between feeder and processor      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface instr_feeder_if;
    logic [15:0] DIN;
    logic        Run;
    logic        Done;

    modport master (output DIN, output Run, input  Done);
    modport slave  (input  DIN, input  Run, output Done);
endinterface
`default_nettype wire

// File: rtl/instr_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | instr_feeder : program store that issues words to processor_multiciclo     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module instr_feeder #(
    parameter int         DEPTH      = 16,
    parameter int         AW         = 4,
    parameter logic [2:0] MVI_OPCODE = 3'b001,
    parameter int         TIMEOUT    = 255
) (
    input  logic          Clock,
    input  logic          Resetn,
    input  logic          wr_en,
    input  logic [15:0]   wr_data,
    input  logic          clr,
    input  logic          start,
    instr_feeder_if.master bus,
    output logic [AW-1:0] pc,
    output logic [AW:0]   count,
    output logic          busy,
    output logic          halted,
    output logic          err
);

    localparam int            c_TW          = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [AW:0]   c_DEPTH_CNT   = (AW + 1)'(DEPTH);
    localparam logic [c_TW-1:0] c_TMO_LAST  = c_TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t          r_state;
    logic [15:0]     r_din;
    logic            r_run;
    logic [AW-1:0]   r_pc;
    logic [AW:0]     r_count;
    logic            r_err;
    logic [c_TW-1:0] r_timer;
    logic            r_start_q;
    logic [15:0]     r_mem [DEPTH];

    logic            w_loading;
    logic            w_full;
    logic            w_mem_we;
    logic            w_start_rise;
    logic [AW:0]     w_pc_inc;
    logic [AW-1:0]   w_pc_nxt;
    logic            w_has_next;

    assign w_loading    = (r_state == S_IDLE) || (r_state == S_HALT);
    assign w_full       = (r_count == c_DEPTH_CNT);
    assign w_start_rise = start & ~r_start_q;
    // Widen before incrementing so the last slot does not alias to index 0.
    assign w_pc_inc     = {1'b0, r_pc} + (AW + 1)'(1);
    assign w_pc_nxt     = w_pc_inc[AW-1:0];
    assign w_has_next   = (w_pc_inc < r_count);
    // Gate with Resetn so a write strobe held through reset never lands.
    assign w_mem_we     = Resetn && w_loading && wr_en && !clr && !w_full;

    always_ff @(posedge Clock) begin
        if (w_mem_we) begin
            r_mem[r_count[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state   <= S_IDLE;
            r_din     <= 16'h0000;
            r_run     <= 1'b0;
            r_pc      <= '0;
            r_count   <= '0;
            r_err     <= 1'b0;
            r_timer   <= '0;
            r_start_q <= 1'b0;
        end else begin
            r_start_q <= start;
            case (r_state)
                S_IDLE, S_HALT: begin
                    if (clr) begin
                        r_count <= '0;
                        r_err   <= 1'b0;
                    end else if (wr_en) begin
                        if (w_full) begin
                            r_err <= 1'b1;
                        end else begin
                            r_count <= r_count + (AW + 1)'(1);
                        end
                    end else if (w_start_rise && (r_count != '0)) begin
                        r_pc    <= '0;
                        r_din   <= r_mem[0];
                        r_run   <= 1'b1;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_run   <= 1'b0;
                    r_timer <= '0;
                    if (r_din[8:6] == MVI_OPCODE) begin
                        if (w_has_next) begin
                            r_pc    <= w_pc_nxt;
                            r_din   <= r_mem[w_pc_nxt];
                            r_state <= S_WAIT;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= S_HALT;
                        end
                    end else begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.Done) begin
                        if (w_has_next) begin
                            r_pc    <= w_pc_nxt;
                            r_din   <= r_mem[w_pc_nxt];
                            r_run   <= 1'b1;
                            r_state <= S_ISSUE;
                        end else begin
                            r_state <= S_HALT;
                        end
                    end else begin
                        r_timer <= r_timer + c_TW'(1);
                        if (r_timer == c_TMO_LAST) begin
                            r_err   <= 1'b1;
                            r_state <= S_HALT;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.DIN = r_din;
    assign bus.Run = r_run;
    assign pc      = r_pc;
    assign count   = r_count;
    assign err     = r_err;
    assign busy    = (r_state == S_ISSUE) || (r_state == S_WAIT);
    assign halted  = (r_state == S_HALT);

endmodule
`default_nettype wire

// File: tb/tb_instr_feeder.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | tb_instr_feeder : directed + random bench against a queue-based model      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_instr_feeder;
    localparam int         DEPTH   = 16;
    localparam int         AW      = 4;
    localparam int         TIMEOUT = 255;
    localparam logic [2:0] MVI     = 3'b001;

    localparam int M_IDLE = 0, M_ISSUE = 1, M_WAIT = 2, M_HALT = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic [15:0]   wr_data = 16'h0000;
    logic          clr = 1'b0;
    logic          start = 1'b0;
    logic          done = 1'b0;
    logic [AW-1:0] pc;
    logic [AW:0]   count;
    logic          busy, halted, err;

    int n_tests = 0;
    int n_fail  = 0;

    instr_feeder_if bus ();
    assign bus.Done = done;

    always #5 clk = ~clk;

    instr_feeder #(
        .DEPTH(DEPTH), .AW(AW), .MVI_OPCODE(MVI), .TIMEOUT(TIMEOUT)
    ) dut (
        .Clock(clk), .Resetn(rst_n), .wr_en(wr_en), .wr_data(wr_data),
        .clr(clr), .start(start), .bus(bus), .pc(pc), .count(count),
        .busy(busy), .halted(halted), .err(err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: program held as a queue, phases named after the behaviour.
    logic [15:0] prog[$];
    int          m_mode;
    logic [15:0] m_din;
    logic        m_run;
    int          m_pc;
    logic        m_err;
    logic        m_sq;
    int          m_wait;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prog.delete();
            m_mode = M_IDLE; m_din = 16'h0000; m_run = 1'b0; m_pc = 0;
            m_err = 1'b0; m_sq = 1'b0; m_wait = 0;
        end else begin
            bit rise;
            rise = start && !m_sq;
            m_sq = start;
            if (m_mode == M_IDLE || m_mode == M_HALT) begin
                if (clr) begin
                    prog.delete();
                    m_err = 1'b0;
                end else if (wr_en) begin
                    if (prog.size() < DEPTH) prog.push_back(wr_data);
                    else m_err = 1'b1;
                end else if (rise && prog.size() > 0) begin
                    m_pc = 0; m_din = prog[0]; m_run = 1'b1; m_mode = M_ISSUE;
                end
            end else if (m_mode == M_ISSUE) begin
                m_run  = 1'b0;
                m_wait = 0;
                if (m_din[8:6] == MVI) begin
                    if (m_pc + 1 < prog.size()) begin
                        m_pc++; m_din = prog[m_pc]; m_mode = M_WAIT;
                    end else begin
                        m_err = 1'b1; m_mode = M_HALT;
                    end
                end else begin
                    m_mode = M_WAIT;
                end
            end else begin
                if (done) begin
                    if (m_pc + 1 < prog.size()) begin
                        m_pc++; m_din = prog[m_pc]; m_run = 1'b1; m_mode = M_ISSUE;
                    end else begin
                        m_mode = M_HALT;
                    end
                end else begin
                    m_wait++;
                    if (m_wait == TIMEOUT) begin
                        m_err = 1'b1; m_mode = M_HALT;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        check("din",    {16'h0, bus.DIN}, {16'h0, m_din});
        check("run",    {31'h0, bus.Run}, {31'h0, m_run});
        check("pc",     {28'h0, pc},      m_pc);
        check("count",  {27'h0, count},   prog.size());
        check("busy",   {31'h0, busy},    {31'h0, (m_mode == M_ISSUE || m_mode == M_WAIT)});
        check("halted", {31'h0, halted},  {31'h0, (m_mode == M_HALT)});
        check("err",    {31'h0, err},     {31'h0, m_err});
    end

    // Processor stand-in: 0 = silent, 1 = Done a fixed delay after Run, 2 = random.
    int resp_mode = 0;
    int resp_delay = 3;
    int resp_cnt = 0;
    always @(negedge clk) begin
        done = 1'b0;
        if (resp_mode == 1) begin
            if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) done = 1'b1;
            end
            if (bus.Run) resp_cnt = resp_delay;
        end else if (resp_mode == 2) begin
            done = ($urandom_range(0, 2) == 0);
        end
    end

    logic [15:0] run_log[$];
    int          wait_cnt = 0;
    always @(negedge clk) begin
        if (bus.Run) run_log.push_back(bus.DIN);
        if (busy && !bus.Run) wait_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input logic [15:0] w);
        wr_en = 1'b1; wr_data = w; tick(1); wr_en = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1; tick(1); clr = 1'b0;
    endtask

    task automatic start_pulse();
        start = 1'b1; tick(1); start = 1'b0; tick(1);
    endtask

    task automatic wait_halt(input int budget);
        for (int i = 0; i < budget && !halted; i++) tick(1);
        check("halt_reached", {31'h0, halted}, 32'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_din"},    {16'h0, bus.DIN}, 32'h0);
        check({tag, "_run"},    {31'h0, bus.Run}, 32'h0);
        check({tag, "_pc"},     {28'h0, pc},      32'h0);
        check({tag, "_count"},  {27'h0, count},   32'h0);
        check({tag, "_busy"},   {31'h0, busy},    32'h0);
        check({tag, "_halted"}, {31'h0, halted},  32'h0);
        check({tag, "_err"},    {31'h0, err},     32'h0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got still running expected finished");
        $fatal(1);
    end

    initial begin
        int base;
        int wbase;

        // Reset held with a write strobe active.
        rst_n = 1'b0; wr_en = 1'b1; wr_data = 16'hABCD;
        tick(3);
        check_reset_values("reset");
        rst_n = 1'b1; wr_en = 1'b0;
        tick(1);
        check("count_after_reset", {27'h0, count}, 32'h0);

        // Two plain instructions, Done three cycles after each Run.
        load(16'h0008); load(16'h0088);
        resp_mode = 1; resp_delay = 3;
        base = run_log.size();
        start_pulse();
        wait_halt(100);
        check("two_runs", run_log.size() - base, 32'd2);
        check("two_din0", {16'h0, run_log[base]},   32'h0008);
        check("two_din1", {16'h0, run_log[base+1]}, 32'h0088);
        check("two_pc",   {28'h0, pc},  32'd1);
        check("two_err",  {31'h0, err}, 32'd0);

        // mvi with its immediate.
        do_clr();
        load(16'h0048); load(16'h0005);
        start = 1'b1; tick(1);
        check("mvi_run", {31'h0, bus.Run}, 32'd1);
        check("mvi_op",  {16'h0, bus.DIN}, 32'h0048);
        start = 1'b0; tick(1);
        check("mvi_imm", {16'h0, bus.DIN}, 32'h0005);
        check("mvi_pc",  {28'h0, pc},      32'd1);
        wait_halt(50);
        check("mvi_err", {31'h0, err}, 32'd0);

        // mvi missing its immediate halts straight from ISSUE.
        do_clr();
        load(16'h0048);
        start = 1'b1; tick(1);
        check("lone_run", {31'h0, bus.Run}, 32'd1);
        start = 1'b0; tick(1);
        check("lone_halt", {31'h0, halted}, 32'd1);
        check("lone_busy", {31'h0, busy},   32'd0);
        check("lone_err",  {31'h0, err},    32'd1);

        // Overflow: 17th write rejected, memory intact, err sticky across a rerun.
        do_clr();
        for (int i = 0; i < DEPTH; i++) load(16'(16'h1000 + i));
        load(16'hFFFF);
        check("full_count", {27'h0, count}, 32'd16);
        check("full_err",   {31'h0, err},   32'd1);
        resp_delay = 1;
        base = run_log.size();
        start_pulse();
        wait_halt(200);
        check("full_runs", run_log.size() - base, 32'd16);
        check("full_last", {16'h0, run_log[run_log.size()-1]}, 32'h100F);
        check("full_err_kept", {31'h0, err}, 32'd1);
        do_clr();
        check("clr_count", {27'h0, count}, 32'd0);
        check("clr_err",   {31'h0, err},   32'd0);
        start_pulse();
        tick(1);
        check("empty_start_busy", {31'h0, busy}, 32'd0);

        // Timeout: Done never arrives.
        load(16'h0008);
        resp_mode = 0;
        wbase = wait_cnt;
        start_pulse();
        wait_halt(400);
        check("timeout_cycles", wait_cnt - wbase, TIMEOUT);
        check("timeout_err", {31'h0, err}, 32'd1);

        // Reset during WAIT and during the Run pulse takes effect at once.
        do_clr();
        load(16'h0008);
        start_pulse();
        tick(2);
        #2 rst_n = 1'b0;
        #1 check_reset_values("rst_wait");
        @(negedge clk) rst_n = 1'b1;
        load(16'h0008);
        start = 1'b1; tick(1); start = 1'b0;
        #2 rst_n = 1'b0;
        #1 check("rst_run_drop", {31'h0, bus.Run}, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        // Random traffic against the model.
        resp_mode = 2;
        for (int c = 0; c < 3000; c++) begin
            logic [15:0] d;
            d = 16'($urandom);
            if ($urandom_range(0, 2) == 0) d[8:6] = MVI;
            wr_data = d;
            wr_en   = ($urandom_range(0, 9) < 2);
            clr     = ($urandom_range(0, 99) < 2);
            if ($urandom_range(0, 4) == 0) start = ~start;
            tick(1);
        end
        wr_en = 1'b0; clr = 1'b0; start = 1'b0; resp_mode = 0;
        tick(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
